// File: rtl/apmu_ibex_pkg.sv
// Shared types and defaults for the APMU Ibex integration, including the PMC writeback queue.
package apmu_ibex_pkg;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } pmc_wbq_entry_t;

  localparam int unsigned PMC_WBQ_DEPTH_DEFAULT  = 4;
  localparam int unsigned PMC_WBQ_STARVE_DEFAULT = 8;

endpackage

// File: rtl/apmu_pmc_wbq_fifo.sv
// Generic power-of-two FIFO for PMC writeback entries; exposes every slot plus a
// per-slot valid mask so the parent can compare all queued destinations at once.
module apmu_pmc_wbq_fifo
  import apmu_ibex_pkg::*;
#(
  parameter int unsigned Depth = PMC_WBQ_DEPTH_DEFAULT
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             push_i,
  input  pmc_wbq_entry_t                   push_data_i,
  input  logic                             pop_i,
  output pmc_wbq_entry_t                   head_o,
  output logic                             full_o,
  output logic                             empty_o,
  output pmc_wbq_entry_t [Depth-1:0]       entries_o,
  output logic           [Depth-1:0]       valid_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic           [PtrW-1:0]  wptr_q, rptr_q;
  logic           [PtrW:0]    count_q;
  pmc_wbq_entry_t [Depth-1:0] mem_q;
  logic                       do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      mem_q   <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o    = mem_q[rptr_q];
  assign entries_o = mem_q;

  // A slot is live when its distance from the read pointer is below the fill count.
  for (genvar i = 0; i < Depth; i++) begin : g_valid
    logic [PtrW-1:0] off;
    assign off        = PtrW'(i) - rptr_q;
    assign valid_o[i] = ({1'b0, off} < count_q);
  end

endmodule

// File: rtl/apmu_pmc_wb_queue.sv
// PMC read-result queue feeding the writeback PMC port in otherwise idle writeback cycles.
// Optional same-cycle bypass of an empty queue: define APMU_PMC_WBQ_BYPASS_EN.
module apmu_pmc_wb_queue
  import apmu_ibex_pkg::*;
#(
  parameter int unsigned Depth       = PMC_WBQ_DEPTH_DEFAULT,
  parameter int unsigned StarveLimit = PMC_WBQ_STARVE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [4:0]  req_waddr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        rf_we_id_i,
  input  logic        rf_we_lsu_i,
  output logic        rf_we_pmc_o,
  output logic [31:0] rf_wdata_pmc_o,
  output logic [4:0]  rf_waddr_pmc_o,
  input  logic [4:0]  hazard_raddr_a_i,
  input  logic [4:0]  hazard_raddr_b_i,
  input  logic [4:0]  hazard_waddr_i,
  output logic        hazard_o,
  output logic        stall_id_o,
  output logic        empty_o
);

  pmc_wbq_entry_t             head, req_entry, last_q, out_entry;
  pmc_wbq_entry_t [Depth-1:0] entries;
  logic           [Depth-1:0] valid;
  logic                       full, empty, slot_free, accept, push, pop, bypass;
  logic           [7:0]       starve_q, starve_d;

  assign req_entry   = '{waddr: req_waddr_i, wdata: req_wdata_i};
  assign req_ready_o = ~full;
  assign empty_o     = empty;
  assign slot_free   = ~rf_we_id_i & ~rf_we_lsu_i;
  assign accept      = req_valid_i & req_ready_o;
  assign pop         = ~empty & slot_free;

`ifdef APMU_PMC_WBQ_BYPASS_EN
  assign bypass = empty & accept & (req_waddr_i != 5'd0) & slot_free;
`else
  assign bypass = 1'b0;
`endif

  // Writes to x0 are accepted but discarded; bypassed requests never occupy a slot.
  assign push = accept & (req_waddr_i != 5'd0) & ~bypass;

  apmu_pmc_wbq_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (req_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .entries_o   (entries),
    .valid_o     (valid)
  );

  always_comb begin
    out_entry = last_q;
    if (!empty) begin
      out_entry = head;
    end
`ifdef APMU_PMC_WBQ_BYPASS_EN
    else if (bypass) begin
      out_entry = req_entry;
    end
`endif
  end

  assign rf_we_pmc_o    = pop | bypass;
  assign rf_waddr_pmc_o = out_entry.waddr;
  assign rf_wdata_pmc_o = out_entry.wdata;

  function automatic logic addr_hit(input logic [4:0] a, input logic [4:0] ra,
                                    input logic [4:0] rb, input logic [4:0] w);
    return (a != 5'd0) && ((a == ra) || (a == rb) || (a == w));
  endfunction

  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (valid[i] && addr_hit(entries[i].waddr, hazard_raddr_a_i, hazard_raddr_b_i,
                               hazard_waddr_i)) begin
        hazard_o = 1'b1;
      end
    end
`ifdef APMU_PMC_WBQ_BYPASS_EN
    if (bypass && addr_hit(req_waddr_i, hazard_raddr_a_i, hazard_raddr_b_i, hazard_waddr_i)) begin
      hazard_o = 1'b1;
    end
`endif
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (!slot_free && (starve_q != 8'(StarveLimit))) begin
      starve_d = starve_q + 8'd1;
    end
  end

  assign stall_id_o = (starve_q == 8'(StarveLimit));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_q <= '0;
      last_q   <= '0;
    end else begin
      starve_q <= starve_d;
      if (rf_we_pmc_o) begin
        last_q <= out_entry;
      end
    end
  end

endmodule

// File: tb/tb_apmu_pmc_wb_queue.sv
// Directed plus randomized bench for apmu_pmc_wb_queue against a queue-based reference model.
module tb_apmu_pmc_wb_queue;

  localparam int Depth = 4;
  localparam int Limit = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o;
  logic [4:0]  req_waddr_i;
  logic [31:0] req_wdata_i;
  logic        rf_we_id_i, rf_we_lsu_i;
  logic        rf_we_pmc_o;
  logic [31:0] rf_wdata_pmc_o;
  logic [4:0]  rf_waddr_pmc_o;
  logic [4:0]  hazard_raddr_a_i, hazard_raddr_b_i, hazard_waddr_i;
  logic        hazard_o, stall_id_o, empty_o;

  always #5 clk_i = ~clk_i;

  apmu_pmc_wb_queue #(
    .Depth       (Depth),
    .StarveLimit (Limit)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_waddr_i      (req_waddr_i),
    .req_wdata_i      (req_wdata_i),
    .rf_we_id_i       (rf_we_id_i),
    .rf_we_lsu_i      (rf_we_lsu_i),
    .rf_we_pmc_o      (rf_we_pmc_o),
    .rf_wdata_pmc_o   (rf_wdata_pmc_o),
    .rf_waddr_pmc_o   (rf_waddr_pmc_o),
    .hazard_raddr_a_i (hazard_raddr_a_i),
    .hazard_raddr_b_i (hazard_raddr_b_i),
    .hazard_waddr_i   (hazard_waddr_i),
    .hazard_o         (hazard_o),
    .stall_id_o       (stall_id_o),
    .empty_o          (empty_o)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [4:0]  last_a;
  logic [31:0] last_d;
  int          starve;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [4:0] a, input logic [31:0] d,
                       input bit id, input bit lsu);
    req_valid_i = v;
    req_waddr_i = a;
    req_wdata_i = d;
    rf_we_id_i  = id;
    rf_we_lsu_i = lsu;
  endtask

  task automatic set_haz(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] w);
    hazard_raddr_a_i = ra;
    hazard_raddr_b_i = rb;
    hazard_waddr_i   = w;
  endtask

  function automatic bit hits(input logic [4:0] a);
    return (a != 0) && (a == hazard_raddr_a_i || a == hazard_raddr_b_i || a == hazard_waddr_i);
  endfunction

  // Check outputs mid-cycle against the model, then advance the model across the edge.
  task automatic cycle();
    bit          slot, ready, byp, we, haz, pop;
    logic [4:0]  ea;
    logic [31:0] ed;
    @(negedge clk_i);
    slot  = !rf_we_id_i && !rf_we_lsu_i;
    ready = q.size() < Depth;
    byp   = 1'b0;
`ifdef APMU_PMC_WBQ_BYPASS_EN
    byp = (q.size() == 0) && req_valid_i && (req_waddr_i != 0) && slot;
`endif
    pop = (q.size() > 0) && slot;
    we  = pop || byp;
    if (q.size() > 0) begin
      ea = q[0].a; ed = q[0].d;
    end else if (byp) begin
      ea = req_waddr_i; ed = req_wdata_i;
    end else begin
      ea = last_a; ed = last_d;
    end
    haz = byp && hits(req_waddr_i);
    foreach (q[i]) if (hits(q[i].a)) haz = 1'b1;
    chk("req_ready", 32'(req_ready_o), 32'(ready));
    chk("rf_we_pmc", 32'(rf_we_pmc_o), 32'(we));
    chk("rf_waddr_pmc", 32'(rf_waddr_pmc_o), 32'(ea));
    chk("rf_wdata_pmc", rf_wdata_pmc_o, ed);
    chk("hazard", 32'(hazard_o), 32'(haz));
    chk("stall_id", 32'(stall_id_o), 32'(starve == Limit));
    chk("empty", 32'(empty_o), 32'(q.size() == 0));
    chk("wb_onehot", 32'(rf_we_pmc_o & (rf_we_id_i | rf_we_lsu_i)), 32'd0);
    @(posedge clk_i);
    if (!rst_ni) begin
      q.delete();
      last_a = '0; last_d = '0; starve = 0;
    end else begin
      if (q.size() == 0 || pop) starve = 0;
      else if (!slot && starve < Limit) starve++;
      if (pop) begin
        last_a = q[0].a; last_d = q[0].d;
        void'(q.pop_front());
      end
      if (byp) begin
        last_a = req_waddr_i; last_d = req_wdata_i;
      end
      if (req_valid_i && ready && req_waddr_i != 0 && !byp)
        q.push_back('{a: req_waddr_i, d: req_wdata_i});
    end
    #1;
  endtask

  initial begin
    bit heavy;
    last_a = '0; last_d = '0; starve = 0;
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0);
    set_haz(0, 0, 0);
    cycle(); cycle();
    rst_ni = 1'b1;
    cycle();

    // Single request, written one cycle later (same cycle with bypass).
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    cycle(); cycle();

    // Fill while ID/EX owns writeback, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(i + 1), 32'h1000 + 32'(i), 1, 0);
      cycle();
    end
    drive(1, 5'd9, 32'h99, 1, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle();

    // Hazard on queued waddr 7; x0 request dropped.
    drive(1, 5'd7, 32'h77, 1, 0);
    cycle();
    drive(0, 0, 0, 1, 0);
    set_haz(3, 7, 4);
    cycle();
    set_haz(0, 0, 0);
    drive(0, 0, 0, 0, 0);
    cycle();
    drive(1, 5'd0, 32'h1234, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    cycle(); cycle();

    // Starvation under continuous LSU traffic.
    drive(1, 5'd11, 32'hABCD, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) cycle();
    drive(0, 0, 0, 0, 0);
    cycle(); cycle(); cycle();

    // Full queue drains while a request waits one cycle for space.
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(i + 12), 32'h5000 + 32'(i), 1, 0);
      cycle();
    end
    drive(1, 5'd20, 32'h5555, 0, 0);
    cycle(); cycle();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle();

    // Reset with entries pending.
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(i + 21), 32'h6000 + 32'(i), 1, 0);
      cycle();
    end
    rst_ni = 1'b0;
    cycle();
    rst_ni = 1'b1;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();
    drive(1, 5'd30, 32'hCAFEF00D, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    cycle(); cycle();

    // Randomized traffic with LSU-heavy phases to exercise starvation.
    heavy = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 40 == 0) heavy = ($urandom_range(0, 2) == 0);
      rst_ni = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) == 0,
            heavy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0));
      set_haz(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
